// File: rtl/datamemory_arbiter.sv
// -----------------------------------------------------------------------------
// datamemory_arbiter
//
// Round-robin arbiter and access sequencer that lets two requesters share the
// single port of the 32 x 64-bit datamemory. Each access walks
// IDLE -> ACCESS -> CAPTURE -> RESP. A request from the other port seen in RESP
// chains straight into ACCESS.
//
// Handshake (REQ/ACK): a requester raises REQx together with stable WEx, ADDRx
// and DINx, and holds all of them until it sees ACKx. ACKx is a one-cycle pulse
// in the RESP cycle. DOUTx already carries the read data in that cycle and then
// holds it. The owner's REQ is ignored during RESP because the requester has not
// yet had a chance to drop it. A new request from the same port is therefore
// only seen after a pass through IDLE.
//
// Ports:
//   CLK, RST          clock; asynchronous active-high reset
//   REQ0/1            request per port
//   WE0/1             1 = write, 0 = read
//   ADDR0/1           word address
//   DIN0/1            write data
//   ACK0/1            one-cycle completion pulse
//   DOUT0/1           read data, updated only on that port's read completion
//   BUSY              high whenever the sequencer is not IDLE
//   MEM_ADDR          memory address
//   MEM_WE            memory write enable
//   MEM_DIN           memory write data
//   MEM_DOUT          memory read data
//   dbg_state         current sequencer state (0 IDLE, 1 ACCESS, 2 CAPTURE,
//                     3 RESP)
// -----------------------------------------------------------------------------
module datamemory_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] DIN0,
  input  logic [DATA_WIDTH-1:0] DIN1,
  output logic                  ACK0,
  output logic                  ACK1,
  output logic [DATA_WIDTH-1:0] DOUT0,
  output logic [DATA_WIDTH-1:0] DOUT1,
  output logic                  BUSY,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic                  MEM_WE,
  output logic [DATA_WIDTH-1:0] MEM_DIN,
  input  logic [DATA_WIDTH-1:0] MEM_DOUT,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  owner_q;   // port that owns the in-flight access
  logic                  last_q;    // most recently granted port
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [DATA_WIDTH-1:0] dout0_q;
  logic [DATA_WIDTH-1:0] dout1_q;

  logic                  take;      // latch a new request at this edge
  logic                  grant;     // port being latched when take is high

  // Next-state and grant selection.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    grant   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          take = 1'b1;
          // On a tie the port that was not granted last wins. Otherwise the
          // single requester wins, which REQ1 alone encodes.
          grant   = (REQ0 && REQ1) ? ~last_q : REQ1;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS:  state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP: begin
        // Only the other port can be taken here; the owner's REQ is stale.
        grant = ~owner_q;
        if (owner_q ? REQ0 : REQ1) begin
          take    = 1'b1;
          state_d = S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      dout0_q <= '0;
      dout1_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        owner_q <= grant;
        last_q  <= grant;
        we_q    <= grant ? WE1 : WE0;
        addr_q  <= grant ? ADDR1 : ADDR0;
        din_q   <= grant ? DIN1 : DIN0;
      end
      // Memory data has had a full cycle to settle by the end of CAPTURE.
      if (state_q == S_CAPTURE && !we_q) begin
        if (owner_q) dout1_q <= MEM_DOUT;
        else         dout0_q <= MEM_DOUT;
      end
    end
  end

  // The memory address and data come straight from the latch registers. They
  // only change when a new request is taken, so they hold while idle.
  assign MEM_ADDR  = addr_q;
  assign MEM_DIN   = din_q;
  assign MEM_WE    = (state_q == S_ACCESS) && we_q;
  assign ACK0      = (state_q == S_RESP) && !owner_q;
  assign ACK1      = (state_q == S_RESP) && owner_q;
  assign BUSY      = (state_q != S_IDLE);
  assign DOUT0     = dout0_q;
  assign DOUT1     = dout1_q;
  assign dbg_state = state_q;

endmodule

// File: doc/datamemory_arbiter.md
# datamemory_arbiter

Two-port arbiter and access sequencer for the 32 x 64-bit `datamemory`. Two requesters (e.g. the load/store unit and a debug/loader port) share the single memory port through a REQ/ACK handshake. The block grants them round-robin and drives the memory's ADDR/WE/D_in. For reads it captures D_out and returns it to the granted requester. It sits between the requesters and `datamemory`, which it drives directly.

## Interface
- `ADDR_WIDTH`, 5: word-address width (32 words).
- `DATA_WIDTH`, 64: data word width.
- `CLK`  in  1  single clock; all state changes on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `REQ0`, `REQ1`  in  1  request from port 0 / port 1; held high until the matching ACK.
- `WE0`, `WE1`  in  1  1 = write, 0 = read; stable while REQx is high.
- `ADDR0`, `ADDR1`  in  ADDR_WIDTH  word address; stable while REQx is high.
- `DIN0`, `DIN1`  in  DATA_WIDTH  write data; stable while REQx is high.
- `ACK0`, `ACK1`  out  1  one-cycle completion pulse for that port.
- `DOUT0`, `DOUT1`  out  DATA_WIDTH  read data for that port; updated only on that port's read completion, then held.
- `BUSY`  out  1  high whenever the state is not IDLE.
- `MEM_ADDR`  out  ADDR_WIDTH  to memory ADDR.
- `MEM_WE`  out  1  to memory WE.
- `MEM_DIN`  out  DATA_WIDTH  to memory D_in.
- `MEM_DOUT`  in  DATA_WIDTH  from memory D_out.

## Operation
- Memory contract:
  - Writes occur on a rising CLK with WE=1.
  - D_out is valid for ADDR no later than one full cycle after ADDR settles.
- State machine: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - If any REQ is high, arbitrate and latch the winner's owner/WE/ADDR/DIN into internal registers, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - MEM_ADDR/MEM_DIN come from the latched registers.
  - MEM_WE = latched WE. This is the only state in which MEM_WE can be 1, so a write asserts it for exactly one cycle.
  - Next state is CAPTURE.
- CAPTURE:
  - MEM_WE=0; MEM_ADDR is held.
  - At the closing edge, a read loads MEM_DOUT into DOUT<owner>. A write leaves DOUTx unchanged.
  - Next state is RESP.
- RESP:
  - ACK<owner>=1.
  - The owner's REQ is ignored this cycle, because the requester sees ACK and has not yet dropped REQ.
  - If the other port's REQ is high, latch it and go straight to ACCESS; otherwise go to IDLE.
- Arbitration:
  - A 1-bit pointer `last` records the most recently granted port.
  - Only one REQ high: that port wins.
  - Both high: the port ≠ `last` wins.
  - `last` updates when the request is latched.
- Outputs in IDLE:
  - MEM_WE=0.
  - MEM_ADDR and MEM_DIN hold their last values (no toggling when idle).
- ACKx and MEM_WE are decoded from registered state/owner only (no combinational path from REQx).
- Reset values: state=IDLE; last=1, so port 0 wins the first tie. ACK0=ACK1=0, BUSY=0, MEM_WE=0, MEM_ADDR=0, MEM_DIN=0, DOUT0=DOUT1=0.
- Reset mid-operation:
  - All of the above is cleared immediately and asynchronously; MEM_WE drops at once.
  - The in-flight access gets no ACK; its requester must reissue.
  - A write is guaranteed complete only once ACK has been seen.
- REQx dropped before ACK: protocol violation; the latched access still completes and ACKs.

## Timing
- Edge numbering: the request is latched at edge k (IDLE→ACCESS).
  - ACCESS occupies cycle k..k+1; the write commits at edge k+1.
  - CAPTURE occupies k+1..k+2; read data is registered at edge k+2.
  - RESP occupies k+2..k+3; ACK and the new DOUT are visible in this cycle.
- Latency: ACK is high in the third cycle after the cycle in which REQ was first sampled high in IDLE.
- Throughput:
  - Alternating ports, back to back: one access per 3 cycles (RESP→ACCESS).
  - Same port repeating: one access per 4 cycles (passes through IDLE).
- Read-after-write to the same address from either port returns the newly written data.

## Test plan
- After reset: ACKx=0, BUSY=0, MEM_WE=0, DOUTx=0. Port 0 writes 150 to address 11 → MEM_WE high exactly one cycle with MEM_ADDR=11, MEM_DIN=150; ACK0 3 cycles after REQ0 is sampled.
- Port 1 reads address 11 after the above → ACK1 with DOUT1=150; DOUT0 unchanged.
- REQ0 and REQ1 rise together right after reset, with port 0 writing 300 to address 11 and port 1 reading address 11:
  - Port 0 is granted first.
  - ACK1 arrives 3 cycles after ACK0, with DOUT1=300.
- Both ports hold REQ continuously for 6 accesses → grants alternate 0,1,0,1,0,1, with ACK spacing of exactly 3 cycles.
- RST pulses mid-ACCESS of a port 0 write of 77 to address 5:
  - MEM_WE drops immediately; no ACK0; outputs return to reset values.
  - On reissue, the write completes and a read of address 5 returns 77.
- Port 0 alone issues back-to-back reads of addresses 0 and 1 (preloaded 10, 20) → DOUT0=10 then 20, with ACK0 spacing of 4 cycles and no grant to port 1.
